// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read forwarding, hardwired x0,
// and a per-register busy scoreboard (reserve at issue, release at writeback).
module regfile_mp #(
  parameter int ADDR_SIZE     = 5,
  parameter int XLEN          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_RD        = 2,
  parameter int NUM_WR        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD-1:0]             read_enable,
  input  logic [NUM_RD*ADDR_SIZE-1:0]   read_addr,
  output logic [NUM_RD*XLEN-1:0]        read_data,
  output logic [NUM_RD-1:0]             read_busy,
  input  logic [NUM_WR-1:0]             write_enable,
  input  logic [NUM_WR*ADDR_SIZE-1:0]   write_addr,
  input  logic [NUM_WR*XLEN-1:0]        write_data,
  input  logic                          reserve_valid,
  input  logic [ADDR_SIZE-1:0]          reserve_addr,
  output logic [NUM_REGISTERS-1:0]      busy_vec
);

  logic [XLEN-1:0]          regs [NUM_REGISTERS];
  logic [NUM_REGISTERS-1:0] busy;

  logic [ADDR_SIZE-1:0] wr_addr  [NUM_WR];
  logic [XLEN-1:0]      wr_data  [NUM_WR];
  logic [NUM_WR-1:0]    wr_valid;

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wr_addr[j]  = write_addr[j*ADDR_SIZE +: ADDR_SIZE];
    assign wr_data[j]  = write_data[j*XLEN +: XLEN];
    assign wr_valid[j] = write_enable[j] && (wr_addr[j] != '0);
  end

  // Later assignments take precedence: higher write port beats lower, reserve beats release.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGISTERS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_valid[j]) begin
          regs[wr_addr[j]] <= wr_data[j];
          busy[wr_addr[j]] <= 1'b0;
        end
      end
      if (reserve_valid && (reserve_addr != '0)) busy[reserve_addr] <= 1'b1;
    end
  end

  assign busy_vec = rst ? '0 : busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [XLEN-1:0]      rd_value;
    logic                 rd_hit;

    assign rd_addr = read_addr[i*ADDR_SIZE +: ADDR_SIZE];

    // Same-cycle writes forward both their data and their release of busy.
    always_comb begin
      rd_hit   = 1'b0;
      rd_value = regs[rd_addr];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_valid[j] && (wr_addr[j] == rd_addr)) begin
          rd_hit   = 1'b1;
          rd_value = wr_data[j];
        end
      end
    end

    always_comb begin
      read_data[i*XLEN +: XLEN] = '0;
      read_busy[i]              = 1'b0;
      if (!rst && read_enable[i] && (rd_addr != '0)) begin
        read_data[i*XLEN +: XLEN] = rd_value;
        read_busy[i]              = busy[rd_addr] & ~rd_hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp (2 read, 2 write ports) against
// an array-based reference model of the register file and scoreboard.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  read_enable;
  logic [9:0]  read_addr;
  logic [63:0] read_data;
  logic [1:0]  read_busy;
  logic [1:0]  write_enable;
  logic [9:0]  write_addr;
  logic [63:0] write_data;
  logic        reserve_valid;
  logic [4:0]  reserve_addr;
  logic [31:0] busy_vec;

  int checks   = 0;
  int failures = 0;

  bit [31:0] model_regs [32];
  bit        model_busy [32];

  regfile_mp #(
    .ADDR_SIZE(5), .XLEN(32), .NUM_REGISTERS(32), .NUM_RD(2), .NUM_WR(2)
  ) dut (
    .clk(clk), .rst(rst),
    .read_enable(read_enable), .read_addr(read_addr),
    .read_data(read_data), .read_busy(read_busy),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle, check combinational outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input bit r, input bit [1:0] ren,
                               input bit [4:0] ra0, input bit [4:0] ra1,
                               input bit [1:0] we,
                               input bit [4:0] wa0, input bit [31:0] wd0,
                               input bit [4:0] wa1, input bit [31:0] wd1,
                               input bit rv, input bit [4:0] rva);
    bit [4:0]  ra  [2];
    bit [4:0]  wa  [2];
    bit [31:0] wd  [2];
    bit [31:0] exp_data;
    bit        exp_busy;
    bit        hit;
    bit [31:0] exp_vec;
    ra[0] = ra0; ra[1] = ra1;
    wa[0] = wa0; wa[1] = wa1;
    wd[0] = wd0; wd[1] = wd1;
    rst           = r;
    read_enable   = ren;
    read_addr     = {ra1, ra0};
    write_enable  = we;
    write_addr    = {wa1, wa0};
    write_data    = {wd1, wd0};
    reserve_valid = rv;
    reserve_addr  = rva;
    #4;
    for (int i = 0; i < 2; i++) begin
      exp_data = 32'h0;
      exp_busy = 1'b0;
      if (!r && ren[i] && ra[i] != 5'd0) begin
        hit      = 1'b0;
        exp_data = model_regs[ra[i]];
        for (int j = 0; j < 2; j++)
          if (we[j] && wa[j] != 5'd0 && wa[j] == ra[i]) begin
            hit      = 1'b1;
            exp_data = wd[j];
          end
        exp_busy = model_busy[ra[i]] && !hit;
      end
      checkOutput($sformatf("read_data%0d_x%0d", i, ra[i]),
                  64'(read_data[i*32 +: 32]), 64'(exp_data));
      checkOutput($sformatf("read_busy%0d_x%0d", i, ra[i]),
                  64'(read_busy[i]), 64'(exp_busy));
    end
    exp_vec = 32'h0;
    if (!r) for (int k = 0; k < 32; k++) exp_vec[k] = model_busy[k];
    checkOutput("busy_vec", 64'(busy_vec), 64'(exp_vec));
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 32; k++) begin
        model_regs[k] = 32'h0;
        model_busy[k] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++)
        if (we[j] && wa[j] != 5'd0) begin
          model_regs[wa[j]] = wd[j];
          model_busy[wa[j]] = 1'b0;
        end
      if (rv && rva != 5'd0) model_busy[rva] = 1'b1;
    end
  endtask

  initial begin
    bit [4:0] a0, a1, w0, w1, rva;

    applyStimulus(1, 2'b11, 5'd1, 5'd2, 2'b11, 5'd1, 32'h1111, 5'd2, 32'h2222, 1, 5'd3);
    applyStimulus(1, 2'b11, 5'd1, 5'd2, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);

    // Every register reads zero and idle after reset.
    for (int a = 1; a < 32; a++)
      applyStimulus(0, 2'b11, 5'(a), 5'(32 - a), 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);

    applyStimulus(0, 2'b11, 5'd5, 5'd5, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 0, 5'd0);
    applyStimulus(0, 2'b11, 5'd5, 5'd6, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);

    applyStimulus(0, 2'b11, 5'd0, 5'd0, 2'b10, 5'd0, 32'h0, 5'd0, 32'h12345678, 1, 5'd0);
    checkOutput("busy_x0_after_reserve", 64'(busy_vec[0]), 64'h0);
    applyStimulus(0, 2'b11, 5'd0, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);

    applyStimulus(0, 2'b11, 5'd7, 5'd7, 2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 0, 5'd0);
    applyStimulus(0, 2'b01, 5'd7, 5'd7, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);

    applyStimulus(0, 2'b11, 5'd9, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, 5'd9);
    checkOutput("busy_x9_after_reserve", 64'(busy_vec[9]), 64'h1);
    applyStimulus(0, 2'b11, 5'd9, 5'd8, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);
    applyStimulus(0, 2'b11, 5'd9, 5'd9, 2'b01, 5'd9, 32'hA5, 5'd0, 32'h0, 0, 5'd0);
    checkOutput("busy_x9_after_release", 64'(busy_vec[9]), 64'h0);
    applyStimulus(0, 2'b11, 5'd9, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);

    applyStimulus(0, 2'b11, 5'd3, 5'd4, 2'b11, 5'd3, 32'h77, 5'd4, 32'h55, 1, 5'd3);
    checkOutput("busy_x3_reserve_wins", 64'(busy_vec[3]), 64'h1);
    applyStimulus(0, 2'b11, 5'd3, 5'd4, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);
    applyStimulus(1, 2'b11, 5'd3, 5'd4, 2'b01, 5'd4, 32'h99, 5'd0, 32'h0, 1, 5'd4);
    applyStimulus(0, 2'b11, 5'd4, 5'd3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, 5'd0);
    checkOutput("busy_vec_clear_after_rst", 64'(busy_vec), 64'h0);

    // Random traffic with addresses biased to a small window to force collisions.
    for (int n = 0; n < 400; n++) begin
      a0  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      w0  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      w1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rva = 5'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom), a0, a1, 2'($urandom),
                    w0, $urandom, w1, $urandom, 1'($urandom), rva);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
